// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach signal controller: GREEN -> YELLOW -> ALLRED per approach,
// with pedestrian green extension and a flashing-yellow override. Outputs decode registers only.
module traffic_phase_ctrl #(
  parameter int NUM_DIR   = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 5,
  parameter int PED_EXT_T = 3,
  parameter int YELLOW_T  = 1,
  parameter int ALLRED_T  = 1,
  localparam int DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 flash_en,
  input  logic [NUM_DIR-1:0]   ped_req,
  output logic [3*NUM_DIR-1:0] light,
  output logic [NUM_DIR-1:0]   walk,
  output logic [DW-1:0]        active_dir,
  output logic [NUM_DIR-1:0]   ped_pend
);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  // Last count value of each state; one bit wider so the extended green cannot wrap.
  localparam logic [CNT_W:0]  LAST_G  = (CNT_W+1)'(GREEN_T - 1);
  localparam logic [CNT_W:0]  LAST_GX = (CNT_W+1)'(GREEN_T + PED_EXT_T - 1);
  localparam logic [CNT_W:0]  LAST_Y  = (CNT_W+1)'(YELLOW_T - 1);
  localparam logic [CNT_W:0]  LAST_AR = (CNT_W+1)'(ALLRED_T - 1);
  localparam logic [DW-1:0]   DIR_MAX = DW'(NUM_DIR - 1);

  state_t               r_state, w_state_nxt;
  logic [DW-1:0]        r_dir, w_dir_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_DIR-1:0]   r_ped_pend;
  logic                 r_walk_act, w_walk_nxt;
  logic                 r_blink, w_blink_nxt;
  logic [NUM_DIR-1:0]   w_ped_clr;
  logic [CNT_W:0]       w_last;
  logic                 w_expire;
  logic [DW-1:0]        w_dir_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_GREEN;
      r_dir      <= '0;
      r_cnt      <= '0;
      r_ped_pend <= '0;
      r_walk_act <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ped_pend <= (r_ped_pend & ~w_ped_clr) | ped_req;
      r_walk_act <= w_walk_nxt;
      r_blink    <= w_blink_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_walk_nxt  = r_walk_act;
    w_blink_nxt = r_blink;
    w_ped_clr   = '0;
    w_dir_inc   = (r_dir == DIR_MAX) ? '0 : r_dir + DW'(1);

    case (r_state)
      S_GREEN:  w_last = r_walk_act ? LAST_GX : LAST_G;
      S_YELLOW: w_last = LAST_Y;
      default:  w_last = LAST_AR;
    endcase
    w_expire = tick && ({1'b0, r_cnt} == w_last);

    // Flash request takes priority over any tick expiry in the same cycle.
    if (flash_en && r_state != S_FLASH) begin
      w_state_nxt = S_FLASH;
      w_cnt_nxt   = '0;
      w_blink_nxt = 1'b1;
      w_walk_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_GREEN: begin
          if (w_expire) begin
            w_state_nxt = S_YELLOW;
            w_cnt_nxt   = '0;
            if (r_walk_act) begin
              w_ped_clr[r_dir] = 1'b1;
              w_walk_nxt       = 1'b0;
            end
          end else if (tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_YELLOW: begin
          if (w_expire) begin
            w_state_nxt = S_ALLRED;
            w_cnt_nxt   = '0;
          end else if (tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_ALLRED: begin
          if (w_expire) begin
            w_state_nxt = S_GREEN;
            w_cnt_nxt   = '0;
            w_dir_nxt   = w_dir_inc;
            w_walk_nxt  = r_ped_pend[w_dir_inc];
          end else if (tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // Leaving flash parks on the last approach so the next handover lands on approach 0.
          if (!flash_en) begin
            w_state_nxt = S_ALLRED;
            w_cnt_nxt   = '0;
            w_dir_nxt   = DIR_MAX;
          end else if (tick) begin
            w_blink_nxt = ~r_blink;
          end
        end
      endcase
    end
  end

  always_comb begin
    light = '0;
    walk  = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (r_state == S_FLASH)
        light[3*d +: 3] = r_blink ? 3'b010 : 3'b000;
      else if (DW'(d) == r_dir && r_state == S_GREEN)
        light[3*d +: 3] = 3'b001;
      else if (DW'(d) == r_dir && r_state == S_YELLOW)
        light[3*d +: 3] = 3'b010;
      else
        light[3*d +: 3] = 3'b100;
    end
    if (r_state == S_GREEN && r_walk_act)
      walk[r_dir] = 1'b1;
  end

  assign active_dir = r_dir;
  assign ped_pend   = r_ped_pend;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl (4 approaches, default timings, tick every 4 clocks).
// Stimulus pushes hand-computed expectations; a monitor compares them after each clock edge.
module tb_traffic_phase_ctrl;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        flash_en;
  logic [3:0]  ped_req;
  logic [11:0] light;
  logic [3:0]  walk;
  logic [1:0]  active_dir;
  logic [3:0]  ped_pend;

  traffic_phase_ctrl #(
    .NUM_DIR(4), .CNT_W(8), .GREEN_T(5), .PED_EXT_T(3), .YELLOW_T(1), .ALLRED_T(1)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .flash_en(flash_en), .ped_req(ped_req),
    .light(light), .walk(walk), .active_dir(active_dir), .ped_pend(ped_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] due;
    logic [11:0] light;
    logic [3:0]  walk;
    logic [1:0]  dir;
    logic [3:0]  pend;
  } exp_t;

  exp_t  q_exp[$];
  string q_nm[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;
  logic  fl    = 1'b0;
  logic  rs    = 1'b1;

  localparam logic [11:0] FON  = 12'h492;
  localparam logic [11:0] FOFF = 12'h000;
  localparam logic [11:0] AR   = 12'h924;

  function automatic logic [11:0] lamp(input int d, input logic [2:0] v);
    logic [11:0] l;
    l = AR;
    l[3*d +: 3] = v;
    return l;
  endfunction

  function automatic logic [11:0] gr(input int d);
    return lamp(d, 3'b001);
  endfunction

  function automatic logic [11:0] ye(input int d);
    return lamp(d, 3'b010);
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h (cycle %0d)", nm, fld, act, req, cyc);
    end
  endtask

  // Monitor: checks every expectation that falls due on this edge.
  always begin
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    while (q_exp.size() > 0 && q_exp[0].due <= cyc) begin
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      cmp(nm, "due",   12'(e.due), 12'(cyc));
      cmp(nm, "light", light, e.light);
      cmp(nm, "walk",  {8'h0, walk}, {8'h0, e.walk});
      cmp(nm, "dir",   {10'h0, active_dir}, {10'h0, e.dir});
      cmp(nm, "pend",  {8'h0, ped_pend}, {8'h0, e.pend});
    end
  end

  task automatic step(input logic t, input logic [3:0] p);
    @(negedge clk);
    tick     = t;
    ped_req  = p;
    flash_en = fl;
    rst      = rs;
    @(posedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [11:0] l, input logic [3:0] w,
                     input logic [1:0] d, input logic [3:0] pd);
    exp_t e;
    e.due = cyc; e.light = l; e.walk = w; e.dir = d; e.pend = pd;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  task automatic tk(input logic [3:0] p, input string nm, input logic [11:0] l,
                    input logic [3:0] w, input logic [1:0] d, input logic [3:0] pd);
    repeat (3) step(1'b0, 4'h0);
    step(1'b1, p);
    chk(nm, l, w, d, pd);
  endtask

  task automatic hold_green(input int d, input int n, input logic [3:0] w, input logic [3:0] pd);
    for (int i = 0; i < n; i++) tk(4'h0, "green_hold", gr(d), w, 2'(d), pd);
  endtask

  initial begin
    tick = 1'b0; flash_en = 1'b0; ped_req = 4'h0; rst = 1'b1;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; flash_en = 1'b0; ped_req = 4'h0;
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    chk("reset", gr(0), 4'h0, 2'd0, 4'h0);
    rs = 1'b0;
    step(1'b0, 4'h0);
    chk("post_reset", gr(0), 4'h0, 2'd0, 4'h0);

    // Call for approach 2 raised during approach 0 green; plain rotation 0 -> 1.
    step(1'b0, 4'b0100);
    chk("ped2_latch", gr(0), 4'h0, 2'd0, 4'b0100);
    hold_green(0, 4, 4'h0, 4'b0100);
    tk(4'h0, "y0", ye(0), 4'h0, 2'd0, 4'b0100);
    tk(4'h0, "ar0", AR, 4'h0, 2'd0, 4'b0100);
    tk(4'h0, "g1", gr(1), 4'h0, 2'd1, 4'b0100);

    // Own-approach call during green without walk waits for the next green.
    step(1'b0, 4'b0010);
    chk("ped1_own_green", gr(1), 4'h0, 2'd1, 4'b0110);
    hold_green(1, 4, 4'h0, 4'b0110);
    tk(4'h0, "y1", ye(1), 4'h0, 2'd1, 4'b0110);
    tk(4'h0, "ar1", AR, 4'h0, 2'd1, 4'b0110);
    tk(4'h0, "g2_walk", gr(2), 4'b0100, 2'd2, 4'b0110);
    hold_green(2, 7, 4'b0100, 4'b0110);
    tk(4'h0, "y2_clear", ye(2), 4'h0, 2'd2, 4'b0010);
    tk(4'h0, "ar2", AR, 4'h0, 2'd2, 4'b0010);
    tk(4'h0, "g3", gr(3), 4'h0, 2'd3, 4'b0010);
    hold_green(3, 4, 4'h0, 4'b0010);
    tk(4'h0, "y3", ye(3), 4'h0, 2'd3, 4'b0010);
    tk(4'h0, "ar3", AR, 4'h0, 2'd3, 4'b0010);
    tk(4'h0, "g0_wrap", gr(0), 4'h0, 2'd0, 4'b0010);
    hold_green(0, 4, 4'h0, 4'b0010);
    tk(4'h0, "y0b", ye(0), 4'h0, 2'd0, 4'b0010);
    tk(4'h0, "ar0b", AR, 4'h0, 2'd0, 4'b0010);
    tk(4'h0, "g1_walk", gr(1), 4'b0010, 2'd1, 4'b0010);
    hold_green(1, 7, 4'b0010, 4'b0010);
    // New call coincides with the clear: set wins.
    tk(4'b0010, "y1_setwins", ye(1), 4'h0, 2'd1, 4'b0010);
    tk(4'h0, "ar1b", AR, 4'h0, 2'd1, 4'b0010);
    tk(4'h0, "g2b", gr(2), 4'h0, 2'd2, 4'b0010);
    hold_green(2, 4, 4'h0, 4'b0010);
    tk(4'h0, "y2b", ye(2), 4'h0, 2'd2, 4'b0010);

    // Flash raised mid-yellow, blink per tick, call latches, release to all-red then approach 0.
    fl = 1'b1;
    step(1'b0, 4'h0);
    chk("flash_entry", FON, 4'h0, 2'd2, 4'b0010);
    tk(4'h0, "flash_blink0", FOFF, 4'h0, 2'd2, 4'b0010);
    step(1'b0, 4'b1000);
    chk("flash_ped_latch", FOFF, 4'h0, 2'd2, 4'b1010);
    tk(4'h0, "flash_blink1", FON, 4'h0, 2'd2, 4'b1010);
    tk(4'h0, "flash_blink2", FOFF, 4'h0, 2'd2, 4'b1010);
    fl = 1'b0;
    step(1'b0, 4'h0);
    chk("flash_exit", AR, 4'h0, 2'd3, 4'b1010);
    tk(4'h0, "flash_g0", gr(0), 4'h0, 2'd0, 4'b1010);

    // Flash on the final green tick: yellow never shown.
    hold_green(0, 4, 4'h0, 4'b1010);
    repeat (3) step(1'b0, 4'h0);
    fl = 1'b1;
    step(1'b1, 4'h0);
    chk("flash_beats_expiry", FON, 4'h0, 2'd0, 4'b1010);
    step(1'b0, 4'h0);
    chk("flash_hold", FON, 4'h0, 2'd0, 4'b1010);
    fl = 1'b0;
    step(1'b1, 4'h0);
    chk("flash_exit2", AR, 4'h0, 2'd3, 4'b1010);
    tk(4'h0, "flash_g0b", gr(0), 4'h0, 2'd0, 4'b1010);

    // Reset in the middle of approach 1 green with calls pending.
    step(1'b0, 4'b0001);
    chk("ped0_latch", gr(0), 4'h0, 2'd0, 4'b1011);
    hold_green(0, 4, 4'h0, 4'b1011);
    tk(4'h0, "y0c", ye(0), 4'h0, 2'd0, 4'b1011);
    tk(4'h0, "ar0c", AR, 4'h0, 2'd0, 4'b1011);
    tk(4'h0, "g1c_walk", gr(1), 4'b0010, 2'd1, 4'b1011);
    hold_green(1, 2, 4'b0010, 4'b1011);
    rs = 1'b1;
    step(1'b0, 4'h0);
    chk("reset_mid", gr(0), 4'h0, 2'd0, 4'h0);
    rs = 1'b0;
    step(1'b0, 4'h0);
    chk("reset_release", gr(0), 4'h0, 2'd0, 4'h0);
    hold_green(0, 4, 4'h0, 4'h0);
    tk(4'h0, "y0_after_reset", ye(0), 4'h0, 2'd0, 4'h0);

    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
